// File: rtl/fetch_prefetch_q_if.sv
// fetch_prefetch_q_if: fetch-stage bundle (control, memory side, decode side).
// The stall_cnt/redir_cnt signals exist only when FETCH_STATS_EN is defined.
interface fetch_prefetch_q_if #(parameter int DATA_W = 16, parameter int ADDR_W = 16);
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              halt;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_done;
  logic [DATA_W-1:0] mem_data;
  logic              mem_err;
  logic              instr_valid;
  logic              instr_ready;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic [ADDR_W-1:0] instr_pc_nxt;
  logic              fetch_stall;
  logic              err;
`ifdef FETCH_STATS_EN
  logic [31:0]       stall_cnt;
  logic [15:0]       redir_cnt;
`endif
  modport master (
`ifdef FETCH_STATS_EN
    output stall_cnt, redir_cnt,
`endif
    input  redirect, redirect_pc, halt, mem_done, mem_data, mem_err, instr_ready,
    output mem_rd, mem_addr, instr_valid, instr, instr_pc, instr_pc_nxt, fetch_stall, err
  );
  modport slave (
`ifdef FETCH_STATS_EN
    input  stall_cnt, redir_cnt,
`endif
    output redirect, redirect_pc, halt, mem_done, mem_data, mem_err, instr_ready,
    input  mem_rd, mem_addr, instr_valid, instr, instr_pc, instr_pc_nxt, fetch_stall, err
  );
endinterface

// File: rtl/fetch_prefetch_q.sv
// fetch_prefetch_q: PC generator + DEPTH-entry prefetch FIFO over a single-outstanding Done/Stall memory.
// Define FETCH_STATS_EN to add saturating stall_cnt/redir_cnt counters.
module fetch_prefetch_q #(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 16,
  parameter int                DEPTH    = 4,
  parameter int                PC_INC   = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic clk,
  input logic rst,
  fetch_prefetch_q_if.master bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);
  typedef enum logic [1:0] {IDLE, REQ, SQUASH, HALT} state_t;
  state_t            state, state_n;
  logic [ADDR_W-1:0] fetch_pc, pend_pc;
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [ADDR_W-1:0] pc_q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [PTR_W:0]    cnt, cnt_nx;
  logic              halt_q, hlt, push, pop, flush, err_q;
  always_comb begin
    hlt = bus.halt | halt_q;
    pop = bus.instr_valid & bus.instr_ready;
    push = (state == REQ) & bus.mem_done & ~bus.redirect;
    flush = bus.redirect & (state != HALT);
    cnt_nx = cnt + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
  end
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else state <= state_n;
  end
  // A redirect racing the outstanding read either drops it now (done) or waits it out in SQUASH.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = hlt ? HALT : (!bus.redirect && cnt < FULL) ? REQ : IDLE;
      REQ:     state_n = bus.redirect ? (bus.mem_done ? IDLE : SQUASH) :
                         !bus.mem_done ? REQ : hlt ? HALT : (cnt_nx < FULL) ? REQ : IDLE;
      SQUASH:  state_n = bus.mem_done ? IDLE : SQUASH;
      HALT:    state_n = HALT;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      pend_pc <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt <= '0;
      halt_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      halt_q <= hlt;
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        cnt <= '0;
      end else begin
        if (push) begin
          data_q[wr_ptr] <= bus.mem_data;
          pc_q[wr_ptr] <= fetch_pc;
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
        if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
        cnt <= cnt_nx;
      end
      if (push) err_q <= err_q | bus.mem_err;
      if (bus.redirect & (state == REQ | state == SQUASH)) pend_pc <= bus.redirect_pc;
      // In SQUASH fetch_pc still holds the squashed address that mem_addr must present.
      fetch_pc <= push ? fetch_pc + ADDR_W'(PC_INC) :
                  (state == SQUASH & bus.mem_done) ? (bus.redirect ? bus.redirect_pc : pend_pc) :
                  (flush & (state == IDLE | bus.mem_done)) ? bus.redirect_pc : fetch_pc;
    end
  end
  always_comb begin
    bus.mem_rd = (state == REQ) | (state == SQUASH);
    bus.mem_addr = fetch_pc;
    bus.instr_valid = cnt != '0;
    bus.instr = bus.instr_valid ? data_q[rd_ptr] : '0;
    bus.instr_pc = bus.instr_valid ? pc_q[rd_ptr] : '0;
    bus.instr_pc_nxt = bus.instr_pc + ADDR_W'(PC_INC);
    bus.fetch_stall = ~bus.instr_valid;
    bus.err = err_q;
  end
`ifdef FETCH_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      bus.stall_cnt <= '0;
      bus.redir_cnt <= '0;
    end else begin
      if (bus.fetch_stall & ~&bus.stall_cnt) bus.stall_cnt <= bus.stall_cnt + 32'd1;
      if (flush & ~&bus.redir_cnt) bus.redir_cnt <= bus.redir_cnt + 16'd1;
    end
  end
`endif
endmodule
